xnor_psum_threshold: RTL and testbench
======================================

// Module: xnor_psum_threshold
// PURPOSE
//  Downstream stage of the XNOR convolution PE array. Accumulates the
//  per-input-channel popcount partial sums (one kxk window per beat) into
//  a full output-pixel sum. Applies a per-filter threshold, which is the
//  folded batch-norm plus sign, and emits one binary activation per pixel.
//  Results go to the next layer's input buffer.
// PARAMETERS
//  PSUM_WIDTH  4   width of incoming popcount (kxk=3x3 -> 0..9)
//  ACC_WIDTH   12  accumulator / threshold width (unsigned)
//  CNT_WIDTH   8   width of beat counter within one pixel group
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           asynchronous reset, active-high
//  thr_we      in   1           threshold load strobe
//  thr_in      in   ACC_WIDTH   threshold value to load
//  thr_inv_in  in   1           invert-sign flag loaded with thr_in (negative BN gamma)
//  psum_valid  in   1           partial-sum beat valid
//  psum_ready  out  1           stage can accept a beat
//  psum_in     in   PSUM_WIDTH  popcount from PE array (zero-extended)
//  psum_last   in   1           beat is last input channel of this pixel
//  act_valid   out  1           binary activation valid
//  act_ready   in   1           consumer accepts activation
//  act_out     out  1           binary activation (1 = +1, 0 = -1)
//  act_sum     out  ACC_WIDTH   final accumulated sum for this activation
//  beat_cnt    out  CNT_WIDTH   beats accepted in current group
//  ovf         out  1           sticky accumulator overflow flag
// BEHAVIOUR
//  Reset values: all outputs 0, except psum_ready = 1.
//   Internal state: acc=0, thr=0, thr_inv=0, state=IDLE.
//  Beat accepted = psum_valid && psum_ready.
//   Activation taken = act_valid && act_ready.
//  psum_ready = !act_valid || act_ready. Combinational; skid-free 1-deep output.
//  FSM states:
//   IDLE: acc is empty.
//    Accepted beat, not last: acc <= psum_in, beat_cnt <= 1, go to ACCUM.
//   ACCUM: accepted beat: acc <= acc + psum_in, beat_cnt <= beat_cnt + 1.
//  Any accepted beat with psum_last=1:
//   - Registers act_sum <= acc_next and act_valid <= 1.
//   - Registers act_out <= (acc_next >= thr) ^ thr_inv.
//   - Clears acc and beat_cnt, returns to IDLE.
//   - acc_next = psum_in in IDLE, acc + psum_in in ACCUM.
//   - A single-beat group (last in IDLE) is legal.
//  Latency: act_valid rises 1 cycle after the last beat is accepted.
//  Throughput: one beat per cycle. A new group may start on the same cycle an activation is taken.
//  Activation taken with no new last beat in the same cycle: act_valid <= 0.
//  Taken together with a last beat: act_valid stays 1 and the new result replaces the old.
//  act_out and act_sum hold stable while act_valid && !act_ready.
//  thr_we: loads thr and thr_inv only when state=IDLE and act_valid=0.
//   Otherwise it is ignored, so the threshold never changes mid-pixel.
//   A load takes effect for the next group.
//  Compare is unsigned, full ACC_WIDTH. thr=0 gives act_out = !thr_inv for every pixel.
//  beat_cnt wraps modulo 2^CNT_WIDTH. A wrap has no other effect.
//  Overflow: carry out of acc + psum_in sets ovf. ovf is sticky until rst.
//  rst mid-group: the partial group and any pending activation are discarded.
// CONFIGURATION
//  XNOR_PSUM_SATURATE_EN defined:
//   On overflow, acc clamps to 2^ACC_WIDTH-1. ovf is still set.
//  XNOR_PSUM_SATURATE_EN undefined:
//   acc wraps modulo 2^ACC_WIDTH and ovf is set.
// TESTING
//  1. Reset, then load thr=20, inv=0.
//     Send beats 9,9,3(last) with act_ready=1.
//     -> Next cycle: act_valid=1, act_sum=21, act_out=1, beat_cnt=0.
//  2. With thr=20, send beats 9,9,1(last) -> act_sum=19, act_out=0.
//     Reload inv=1, repeat -> act_out=1.
//  3. Backpressure: hold act_ready=0 after a result.
//     -> psum_ready=0 and act_out/act_sum hold stable.
//     Raise act_ready while a last beat is valid -> back-to-back results, no bubble.
//  4. thr_we asserted during ACCUM -> ignored; the current and next pixels use the old threshold.
//  5. ACC_WIDTH=4, beats 9,9(last):
//     -> act_sum=2 (wrap) or 15 with XNOR_PSUM_SATURATE_EN; ovf=1 in both builds.
//  6. Assert rst after 2 beats with act_valid=1.
//     -> Next result counts only post-reset beats; act_valid=0 until then.

Source files
------------

// File: rtl/xnor_psum_threshold.sv
// Accumulates per-channel XNOR popcounts into a pixel sum and thresholds it to a binary activation.
// Build option: define XNOR_PSUM_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module xnor_psum_threshold #(
  parameter int PSUM_WIDTH = 4,
  parameter int ACC_WIDTH  = 12,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  thr_we,
  input  logic [ACC_WIDTH-1:0]  thr_in,
  input  logic                  thr_inv_in,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  input  logic                  psum_last,
  output logic                  act_valid,
  input  logic                  act_ready,
  output logic                  act_out,
  output logic [ACC_WIDTH-1:0]  act_sum,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  ovf
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t               state_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] thr_r;
  logic                 thr_inv_r;

  logic                 beat_take_s;
  logic                 act_take_s;
  logic [ACC_WIDTH-1:0] acc_base_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic [ACC_WIDTH-1:0] acc_next_s;

  // The output register is only one deep, so a beat may enter only if the result slot frees up.
  assign psum_ready  = !act_valid || act_ready;
  assign beat_take_s = psum_valid && psum_ready;
  assign act_take_s  = act_valid && act_ready;

  // Next accumulator value with carry detection; an empty accumulator contributes zero.
  always_comb begin
    acc_base_s = {ACC_WIDTH{1'b0}};
    case (state_r)
      IDLE:    acc_base_s = {ACC_WIDTH{1'b0}};
      ACCUM:   acc_base_s = acc_r;
      default: acc_base_s = {ACC_WIDTH{1'b0}};
    endcase
    sum_s = {1'b0, acc_base_s} + {{(ACC_WIDTH + 1 - PSUM_WIDTH){1'b0}}, psum_in};
`ifdef XNOR_PSUM_SATURATE_EN
    if (sum_s[ACC_WIDTH]) begin
      acc_next_s = {ACC_WIDTH{1'b1}};
    end else begin
      acc_next_s = sum_s[ACC_WIDTH-1:0];
    end
`else
    acc_next_s = sum_s[ACC_WIDTH-1:0];
`endif
  end

  // Group FSM, threshold registers and registered activation outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      acc_r     <= {ACC_WIDTH{1'b0}};
      thr_r     <= {ACC_WIDTH{1'b0}};
      thr_inv_r <= 1'b0;
      act_valid <= 1'b0;
      act_out   <= 1'b0;
      act_sum   <= {ACC_WIDTH{1'b0}};
      beat_cnt  <= {CNT_WIDTH{1'b0}};
      ovf       <= 1'b0;
    end else begin
      // Threshold only moves between pixels so a group never sees two thresholds.
      if (thr_we && (state_r == IDLE) && !act_valid) begin
        thr_r     <= thr_in;
        thr_inv_r <= thr_inv_in;
      end

      if (beat_take_s && sum_s[ACC_WIDTH]) begin
        ovf <= 1'b1;
      end

      if (beat_take_s && psum_last) begin
        act_valid <= 1'b1;
        act_sum   <= acc_next_s;
        act_out   <= (acc_next_s >= thr_r) ^ thr_inv_r;
      end else if (act_take_s) begin
        act_valid <= 1'b0;
      end

      if (beat_take_s) begin
        if (psum_last) begin
          acc_r    <= {ACC_WIDTH{1'b0}};
          beat_cnt <= {CNT_WIDTH{1'b0}};
          state_r  <= IDLE;
        end else begin
          acc_r   <= acc_next_s;
          state_r <= ACCUM;
          case (state_r)
            IDLE:    beat_cnt <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            ACCUM:   beat_cnt <= beat_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            default: beat_cnt <= {CNT_WIDTH{1'b0}};
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_xnor_psum_threshold.sv
// Scoreboard bench for xnor_psum_threshold: directed scenarios plus randomized groups against a sum-level model.
module tb_xnor_psum_threshold;

  localparam int AW   = 12;
  localparam int AMAX = (1 << AW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          thr_we, thr_inv_in, psum_valid, psum_last, act_ready;
  logic [AW-1:0] thr_in;
  logic [3:0]    psum_in;
  logic          psum_ready, act_valid, act_out, ovf;
  logic [AW-1:0] act_sum;
  logic [7:0]    beat_cnt;

  logic          s_psum_valid, s_psum_last, s_psum_ready, s_act_valid, s_act_out, s_ovf;
  logic [3:0]    s_psum_in, s_act_sum;
  logic [7:0]    s_beat_cnt;

  xnor_psum_threshold dut (
    .clk(clk), .rst(rst), .thr_we(thr_we), .thr_in(thr_in), .thr_inv_in(thr_inv_in),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_in(psum_in), .psum_last(psum_last),
    .act_valid(act_valid), .act_ready(act_ready), .act_out(act_out), .act_sum(act_sum),
    .beat_cnt(beat_cnt), .ovf(ovf)
  );

  // Narrow accumulator instance used for the overflow behaviour.
  xnor_psum_threshold #(.PSUM_WIDTH(4), .ACC_WIDTH(4), .CNT_WIDTH(8)) dut_small (
    .clk(clk), .rst(rst), .thr_we(1'b0), .thr_in(4'd0), .thr_inv_in(1'b0),
    .psum_valid(s_psum_valid), .psum_ready(s_psum_ready), .psum_in(s_psum_in), .psum_last(s_psum_last),
    .act_valid(s_act_valid), .act_ready(1'b1), .act_out(s_act_out), .act_sum(s_act_sum),
    .beat_cnt(s_beat_cnt), .ovf(s_ovf)
  );

  typedef struct {
    int sum;
    bit act;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: total of the open group, its beat count, pending-result flag, threshold.
  int grp_total, grp_beats, m_thr;
  bit m_pend, m_ovf, m_inv;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t predict(input int total);
    exp_t p;
`ifdef XNOR_PSUM_SATURATE_EN
    p.sum = (total > AMAX) ? AMAX : total;
`else
    p.sum = total % (AMAX + 1);
`endif
    p.act = (p.sum >= m_thr) ^ m_inv;
    return p;
  endfunction

  task automatic model_clear();
    grp_total = 0; grp_beats = 0; m_thr = 0; m_inv = 0; m_pend = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  // One clock of stimulus: drive after negedge, check just before posedge, then advance the model.
  task automatic step(input bit v, input int d, input bit l, input bit r,
                      input bit we, input int t, input bit inv);
    bit acc, take, idle_pre;
    @(negedge clk);
    psum_valid = v; psum_in = d[3:0]; psum_last = l; act_ready = r;
    thr_we = we; thr_in = t[AW-1:0]; thr_inv_in = inv;
    #4;
    check("psum_ready", 32'(psum_ready), 32'(!m_pend || r));
    check("act_valid", 32'(act_valid), 32'(m_pend));
    check("beat_cnt", 32'(beat_cnt), grp_beats % 256);
    check("ovf", 32'(ovf), 32'(m_ovf));
    acc      = v && (!m_pend || r);
    take     = m_pend && r;
    idle_pre = (grp_beats == 0) && !m_pend;
    if (acc) begin
      grp_total += d;
      grp_beats++;
      if (grp_total > AMAX) m_ovf = 1'b1;
      if (l) begin
        exp_q.push_back(predict(grp_total));
        grp_total = 0;
        grp_beats = 0;
      end
    end
    if (acc && l) m_pend = 1'b1;
    else if (take) m_pend = 1'b0;
    if (we && idle_pre) begin
      m_thr = t;
      m_inv = inv;
    end
  endtask

  task automatic beat(input int d, input bit l);
    step(1'b1, d, l, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic load(input int t, input bit inv);
    step(1'b0, 0, 1'b0, 1'b1, 1'b1, t, inv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; psum_valid = 1'b0; act_ready = 1'b0; thr_we = 1'b0; s_psum_valid = 1'b0;
    #4;
    check("rst_act_valid", 32'(act_valid), 32'd0);
    check("rst_psum_ready", 32'(psum_ready), 32'd1);
    check("rst_act_sum", 32'(act_sum), 32'd0);
    check("rst_act_out", 32'(act_out), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_small_ovf", 32'(s_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Monitor: pops the scoreboard on every taken activation and checks stability under backpressure.
  logic [AW-1:0] hold_sum;
  logic          hold_out;
  bit            hold_chk = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          check("hold_sum", 32'(act_sum), 32'(hold_sum));
          check("hold_out", 32'(act_out), 32'(hold_out));
        end
        hold_chk = 1'b0;
        if (act_valid && act_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected", 32'(act_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("act_sum", 32'(act_sum), e.sum);
            check("act_out", 32'(act_out), 32'(e.act));
          end
        end else if (act_valid) begin
          hold_chk = 1'b1;
          hold_sum = act_sum;
          hold_out = act_out;
        end
      end
    end
  end

  initial begin
    int  nb, b, small_exp;
    bit  v, r;
    rst = 1'b1; thr_we = 1'b0; thr_in = '0; thr_inv_in = 1'b0;
    psum_valid = 1'b0; psum_in = '0; psum_last = 1'b0; act_ready = 1'b0;
    s_psum_valid = 1'b0; s_psum_in = '0; s_psum_last = 1'b0;
    do_reset();

    // Basic group: 9+9+3 = 21 against threshold 20.
    load(20, 1'b0);
    beat(9, 1'b0); beat(9, 1'b0); beat(3, 1'b1);
    idle(1);
    check("t1_sum", 32'(act_sum), 32'd21);
    check("t1_out", 32'(act_out), 32'd1);

    // Below threshold, a load ignored while a result is pending, then inverted sign.
    beat(9, 1'b0); beat(9, 1'b0); beat(1, 1'b1);
    load(20, 1'b1);
    idle(1);
    check("t2_below", 32'(act_out), 32'd0);
    load(20, 1'b1);
    beat(9, 1'b0); beat(9, 1'b0); beat(1, 1'b1);
    idle(1);
    check("t2_inv", 32'(act_out), 32'd1);
    load(20, 1'b0);

    // Backpressure, then release while a last beat waits: back-to-back results.
    beat(5, 1'b0); beat(5, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 7, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 7, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 4, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    idle(2);

    // Load attempted mid-pixel is ignored for this and the next pixel.
    beat(9, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b1, 5, 1'b1);
    beat(9, 1'b1);
    idle(1);
    check("t4_cur", 32'(act_out), 32'd0);
    beat(9, 1'b0); beat(9, 1'b0); beat(9, 1'b0); beat(3, 1'b1);
    idle(1);
    check("t4_next", 32'(act_out), 32'd1);

    // Beat counter wraps modulo 256 without disturbing the sum.
    for (int i = 0; i < 259; i++) beat(1, 1'b0);
    beat(1, 1'b1);
    idle(2);

    // Narrow accumulator: 9+9 overflows a 4-bit sum.
`ifdef XNOR_PSUM_SATURATE_EN
    small_exp = 15;
`else
    small_exp = 2;
`endif
    @(negedge clk); s_psum_valid = 1'b1; s_psum_in = 4'd9; s_psum_last = 1'b0;
    @(negedge clk); s_psum_in = 4'd9; s_psum_last = 1'b1;
    @(negedge clk); s_psum_valid = 1'b0; #4;
    check("t5_valid", 32'(s_act_valid), 32'd1);
    check("t5_sum", 32'(s_act_sum), small_exp);
    check("t5_ovf", 32'(s_ovf), 32'd1);
    check("t5_thr0", 32'(s_act_out), 32'd1);
    @(negedge clk); s_psum_valid = 1'b1; s_psum_in = 4'd1; s_psum_last = 1'b0;
    @(negedge clk); s_psum_in = 4'd2; s_psum_last = 1'b1;
    @(negedge clk); s_psum_valid = 1'b0; #4;
    check("t5_sum2", 32'(s_act_sum), 32'd3);
    check("t5_sticky", 32'(s_ovf), 32'd1);

    // Reset with a pending result, and reset mid-group.
    load(20, 1'b0);
    beat(9, 1'b0); beat(9, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    do_reset();
    beat(2, 1'b0); beat(3, 1'b1);
    idle(1);
    check("t6_sum", 32'(act_sum), 32'd5);
    beat(9, 1'b0); beat(9, 1'b0);
    do_reset();
    beat(1, 1'b1);
    idle(1);
    check("t6_partial", 32'(act_sum), 32'd1);

    // Randomized groups with random gaps, backpressure and stray threshold writes.
    for (int g = 0; g < 150; g++) begin
      if (g % 25 == 0) begin
        idle(2);
        load($urandom_range(0, 120), 1'($urandom_range(0, 1)));
      end
      nb = $urandom_range(1, 12);
      b  = 0;
      while (b < nb) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 9) < 7);
        if (!v && $urandom_range(0, 9) == 0) begin
          step(1'b0, 0, 1'b0, r, 1'b1, $urandom_range(0, 120), 1'($urandom_range(0, 1)));
        end else begin
          if (v && (!m_pend || r)) b++;
          step(v, $urandom_range(0, 9), (b == nb) && v, r, 1'b0, 0, 1'b0);
        end
      end
    end
    idle(3);
    check("sb_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
